// File: rtl/rfu.sv
// rfu - register-file unit for the RV32E core.
//
// Holds NREG architectural registers with two combinational read ports,
// one commit port shared by the LSU and the EXU, and a per-register busy
// scoreboard. The issue stage uses the scoreboard to detect RAW and WAW
// hazards.
//
// Ports:
//   clk                clock
//   rst                asynchronous reset, active low
//   rs1_addr/rs2_addr  read addresses
//   rs1_data/rs2_data  read data (combinational, with commit bypass)
//   rs1_busy/rs2_busy  addressed register still has a pending write
//   rsv_valid/rsv_addr/rsv_ready   destination reservation handshake
//   ex_valid/ex_addr/ex_data/ex_ready   EXU result write port
//   ld_valid/ld_addr/ld_data/ld_ready   LSU load write port (always ready)
//
// Only one commit happens per cycle, and the LSU has priority. x0 always
// reads as zero and is never marked busy.
module rfu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 16,
  parameter int unsigned AW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ready,
  input  logic            ex_valid,
  input  logic [AW-1:0]   ex_addr,
  input  logic [XLEN-1:0] ex_data,
  output logic            ex_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic            commit_valid;
  logic [AW-1:0]   commit_addr;
  logic [XLEN-1:0] commit_data;
  logic            hit1;
  logic            hit2;
  logic            rsv_fire;

  // No commit can happen while reset is held, so the bypass is inactive.
  assign commit_valid = rst && (ld_valid || ex_valid);
  assign commit_addr  = ld_valid ? ld_addr : ex_addr;
  assign commit_data  = ld_valid ? ld_data : ex_data;

  assign ld_ready = 1'b1;
  assign ex_ready = rst && !ld_valid;

  assign hit1 = commit_valid && (commit_addr != '0) && (commit_addr == rs1_addr);
  assign hit2 = commit_valid && (commit_addr != '0) && (commit_addr == rs2_addr);

  assign rs1_data = hit1 ? commit_data :
                    (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = hit2 ? commit_data :
                    (rs2_addr == '0) ? '0 : regs[rs2_addr];

  assign rs1_busy = busy[rs1_addr] && !hit1;
  assign rs2_busy = busy[rs2_addr] && !hit2;

  assign rsv_ready = !rst || (rsv_addr == '0) || !busy[rsv_addr] ||
                     (commit_valid && (commit_addr == rsv_addr));
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != '0);

  // The reservation is applied after the commit clear, so when both target
  // the same register in one cycle, it ends up busy.
  always_comb begin
    busy_nxt = busy;
    if (commit_valid) busy_nxt[commit_addr] = 1'b0;
    if (rsv_fire)     busy_nxt[rsv_addr]    = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (commit_valid && (commit_addr != '0)) regs[commit_addr] <= commit_data;
      busy <= busy_nxt;
    end
  end

endmodule
